mult_controller: RTL

Sequencing and sign-handling controller for the shared pipelined 32x32 unsigned multiplier in the CPU execute stage. Accepts MULT/MULTU requests with a valid/ready handshake, drives operand magnitudes into the multiplier, and tracks every in-flight operation through the multiplier latency. Sign-corrects each product and writes it into the architectural HI/LO registers. Exposes a busy interlock so MFHI/MFLO stall until all issued multiplies have retired.

---
 rtl/mult_controller.sv | 101 ++++++++++
 1 files changed

// File: rtl/mult_controller.sv
// Sequencing and sign-handling controller for a shared pipelined unsigned multiplier, owning HI/LO.
// Define MULT_SIGNED_EN to build the signed (MULT) path; otherwise every request is treated as MULTU.
module mult_controller #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_signed,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_r,
    input  logic               mthi_en,
    input  logic               mtlo_en,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               hilo_busy,
    output logic               done
);

    localparam int DEPTH = MUL_LATENCY + 1;

    logic                 accept;
    logic [DEPTH-1:0]     vld_p;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [2*WIDTH-1:0]   retire_val;

    assign req_ready = !reset;
    assign accept    = req_valid && req_ready;
    assign hilo_busy = |vld_p;

`ifdef MULT_SIGNED_EN
    logic [DEPTH-1:0] neg_p;
    logic             neg_in;

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] u;
        u = x;
        return x[WIDTH-1] ? -u : u;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                       input logic neg);
        return neg ? -p : p;
    endfunction

    assign neg_in     = req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
    assign op_a       = req_signed ? magnitude(req_a) : req_a;
    assign op_b       = req_signed ? magnitude(req_b) : req_b;
    assign retire_val = apply_sign(mul_r, neg_p[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_p <= '0;
        end else begin
            neg_p <= {neg_p[DEPTH-2:0], neg_in};
        end
    end
`else
    logic unused_req_signed;

    assign unused_req_signed = req_signed;
    assign op_a              = req_a;
    assign op_b              = req_b;
    assign retire_val        = mul_r;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
            mul_a <= '0;
            mul_b <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            // stage 0: operand capture; tracking entry follows the multiplier
            vld_p <= {vld_p[DEPTH-2:0], accept};
            if (accept) begin
                mul_a <= op_a;
                mul_b <= op_b;
            end
            // final stage: retire into HI/LO, explicit moves override their half
            done <= vld_p[DEPTH-1];
            if (vld_p[DEPTH-1]) begin
                hi <= retire_val[2*WIDTH-1:WIDTH];
                lo <= retire_val[WIDTH-1:0];
            end
            if (mthi_en) hi <= wdata;
            if (mtlo_en) lo <= wdata;
        end
    end

endmodule
